// File: rtl/aemb_sysctl_pkg.sv
// Shared definitions for the aeMB system control unit: arbiter state
// encodings and their width.
package aemb_sysctl_pkg;

  localparam int FSM_W = 2;

  typedef enum logic [FSM_W-1:0] {
    RUN   = 2'd0,
    HWINT = 2'd1,
    HWEXC = 2'd2,
    SWEXC = 2'd3
  } fsm_e;

endpackage

// File: rtl/aemb_sysctl_deb.sv
// One-line debouncer: DEB-sample shift register plus rising-edge qualifier.
// The edge is judged on the value being shifted in, so it fires on the same
// clock that captures the (DEB-1)-th high sample.
module aemb_sysctl_deb #(
  parameter int DEB = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_i,
  input  logic en_i,
  input  logic d_i,
  output logic edge_o
);

  logic [DEB-1:0] sh_q;
  logic [DEB-1:0] sh_d;

  assign sh_d   = {sh_q[DEB-2:0], d_i};
  assign edge_o = en_i & ~hold_i & (&sh_d[DEB-2:0]) & ~sh_d[DEB-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q <= '0;
    end else if (hold_i) begin
      sh_q <= '0;
    end else if (en_i) begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/aemb_sysctl.sv
// aeMB system control: clock/reset generation, bus-quiet run strobe,
// fetch/decode bubbles and acknowledge-handshaked interrupt arbitration.
module aemb_sysctl
  import aemb_sysctl_pkg::*;
#(
  parameter  int NINT   = 4,
  parameter  int DEB    = 3,
  parameter  int RSTLEN = 2,
  localparam int IW     = (NINT > 1) ? $clog2(NINT) : 1
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [NINT-1:0] sys_int_i,
  input  logic            sys_exc_i,
  input  logic            swx_i,
  input  logic            ie_i,
  input  logic [NINT-1:0] int_msk_i,
  input  logic            ack_i,
  input  logic            rIWBSTB,
  input  logic            iwb_ack_i,
  input  logic            rDWBSTB,
  input  logic            dwb_ack_i,
  input  logic            rBRA,
  input  logic            rDLY,
  output logic            nclk,
  output logic            nrst,
  output logic            nrun,
  output logic            frun,
  output logic            drun,
  output logic [1:0]      rFSM,
  output logic [IW-1:0]   int_id_o,
  output logic [NINT-1:0] pend_o
);

  function automatic logic [IW-1:0] prio_enc(input logic [NINT-1:0] v);
    prio_enc = '0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = IW'(i);
    end
  endfunction

  logic [RSTLEN-1:0] rst_q, rst_d;
  logic [NINT:0]     raw, edg;
  logic [NINT-1:0]   pend_q, pend_d, elig, clr_vec;
  logic              exc_q, exc_d, swx_q, swx_d;
  logic              clr_int, clr_exc, clr_swx;
  fsm_e              fsm_q, fsm_d;
  logic [IW-1:0]     id_q, id_d;
  logic              frun_q, frun_d, drun_q, drun_d;

  assign nclk = sys_clk_i;
  assign nrun = ~((rDWBSTB ^ dwb_ack_i) | (rIWBSTB ^ iwb_ack_i));

  always_comb begin
    rst_d    = rst_q << 1;
    rst_d[0] = 1'b1;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) rst_q <= '0;
    else            rst_q <= rst_d;
  end

  assign nrst = rst_q[RSTLEN-1];

  // Bit 0 is the hardware exception; bits 1..NINT are the interrupt lines.
  assign raw = {sys_int_i, sys_exc_i};

  for (genvar g = 0; g <= NINT; g++) begin : g_deb
    aemb_sysctl_deb #(.DEB(DEB)) u_deb (
      .clk_i  (sys_clk_i),
      .rst_ni (sys_rst_i),
      .hold_i (~nrst),
      .en_i   (nrun),
      .d_i    (raw[g]),
      .edge_o (edg[g])
    );
  end

  assign elig = ie_i ? (pend_q & ~int_msk_i) : '0;

  always_comb begin
    fsm_d   = fsm_q;
    id_d    = id_q;
    clr_int = 1'b0;
    clr_exc = 1'b0;
    clr_swx = 1'b0;
    case (fsm_q)
      RUN: begin
        if (nrun) begin
          if (swx_q) begin
            fsm_d = SWEXC;
          end else if (exc_q) begin
            fsm_d = HWEXC;
          end else if (|elig) begin
            fsm_d = HWINT;
            id_d  = prio_enc(elig);
          end
        end
      end
      HWINT: if (ack_i) begin fsm_d = RUN; clr_int = 1'b1; end
      HWEXC: if (ack_i) begin fsm_d = RUN; clr_exc = 1'b1; end
      SWEXC: if (ack_i) begin fsm_d = RUN; clr_swx = 1'b1; end
      default: fsm_d = RUN;
    endcase
  end

  // New requests are OR-ed in after the clear so a same-cycle set wins.
  always_comb begin
    clr_vec = clr_int ? (NINT'(1) << id_q) : '0;
    pend_d  = (pend_q & ~clr_vec) | edg[NINT:1];
    exc_d   = (exc_q & ~clr_exc) | edg[0];
    swx_d   = (swx_q & ~clr_swx) | swx_i;
    if (fsm_d == RUN) begin
      drun_d = ~(rBRA ^ rDLY);
      frun_d = ~rBRA;
    end else begin
      drun_d = 1'b0;
      frun_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      fsm_q  <= RUN;
      id_q   <= '0;
      pend_q <= '0;
      exc_q  <= 1'b0;
      swx_q  <= 1'b0;
      frun_q <= 1'b1;
      drun_q <= 1'b1;
    end else if (!nrst) begin
      fsm_q  <= RUN;
      id_q   <= '0;
      pend_q <= '0;
      exc_q  <= 1'b0;
      swx_q  <= 1'b0;
      frun_q <= 1'b1;
      drun_q <= 1'b1;
    end else begin
      fsm_q  <= fsm_d;
      id_q   <= id_d;
      pend_q <= pend_d;
      exc_q  <= exc_d;
      swx_q  <= swx_d;
      frun_q <= frun_d;
      drun_q <= drun_d;
    end
  end

  assign rFSM     = fsm_q;
  assign int_id_o = id_q;
  assign pend_o   = pend_q;
  assign frun     = frun_q;
  assign drun     = drun_q;

endmodule

// File: tb/tb_aemb_sysctl.sv
// Directed bench for aemb_sysctl: expectations are queued as stimulus is
// applied and popped against the observed outputs after each clock edge.
module tb_aemb_sysctl;

  localparam int NINT   = 4;
  localparam int DEB    = 3;
  localparam int RSTLEN = 2;
  localparam int IW     = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NINT-1:0] sys_int;
  logic            sys_exc, swx, ie, ack;
  logic [NINT-1:0] msk;
  logic            iwbstb, iwback, dwbstb, dwback, bra, dly;
  logic            nclk, nrst, nrun, frun, drun;
  logic [1:0]      fsm;
  logic [IW-1:0]   id;
  logic [NINT-1:0] pend;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } sb_t;

  sb_t sbq[$];

  logic [11:0] obs;
  assign obs = {nrst, fsm, id, pend, drun, frun, nrun};

  always #5 clk = ~clk;

  aemb_sysctl #(.NINT(NINT), .DEB(DEB), .RSTLEN(RSTLEN)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst_n),
    .sys_int_i (sys_int),
    .sys_exc_i (sys_exc),
    .swx_i     (swx),
    .ie_i      (ie),
    .int_msk_i (msk),
    .ack_i     (ack),
    .rIWBSTB   (iwbstb),
    .iwb_ack_i (iwback),
    .rDWBSTB   (dwbstb),
    .dwb_ack_i (dwback),
    .rBRA      (bra),
    .rDLY      (dly),
    .nclk      (nclk),
    .nrst      (nrst),
    .nrun      (nrun),
    .frun      (frun),
    .drun      (drun),
    .rFSM      (fsm),
    .int_id_o  (id),
    .pend_o    (pend)
  );

  function automatic logic [11:0] mk(input logic n, input logic [1:0] f,
                                     input logic [1:0] i, input logic [3:0] p,
                                     input logic dr, input logic fr,
                                     input logic nr);
    return {n, f, i, p, dr, fr, nr};
  endfunction

  task automatic push(input string tag, input logic [11:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [11:0] v);
    push(tag, v);
    tick(1);
    drain();
  endtask

  task automatic now(input string tag, input logic [11:0] v);
    push(tag, v);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sys_int = '0; sys_exc = 1'b0; swx = 1'b0; ie = 1'b0;
    ack = 1'b0; msk = '0; iwbstb = 1'b0; iwback = 1'b0; dwbstb = 1'b0;
    dwback = 1'b0; bra = 1'b0; dly = 1'b0;

    tick(2);
    now("rst_hold", mk(0, 0, 0, 4'b0000, 1, 1, 1));
    total++;
    assert (nclk === clk) else begin
      bad++;
      $error("FAIL nclk observed=%b expected=%b", nclk, clk);
    end
    rst_n = 1'b1;
    step("rst_edge1", mk(0, 0, 0, 4'b0000, 1, 1, 1));
    step("rst_edge2", mk(1, 0, 0, 4'b0000, 1, 1, 1));

    ie = 1'b1; sys_int = 4'b0100;
    step("int_s1",    mk(1, 0, 0, 4'b0000, 1, 1, 1));
    step("int_pend",  mk(1, 0, 0, 4'b0100, 1, 1, 1));
    step("int_enter", mk(1, 1, 2, 4'b0100, 0, 0, 1));
    ack = 1'b1;
    step("int_ack",   mk(1, 0, 2, 4'b0000, 1, 1, 1));
    ack = 1'b0;
    push("int_noretrig", mk(1, 0, 2, 4'b0000, 1, 1, 1));
    tick(3);
    drain();
    sys_int = '0;
    tick(3);

    sys_int = 4'b1010; sys_exc = 1'b1;
    step("pri_s1",    mk(1, 0, 2, 4'b0000, 1, 1, 1));
    step("pri_pend",  mk(1, 0, 2, 4'b1010, 1, 1, 1));
    step("pri_hwexc", mk(1, 2, 2, 4'b1010, 0, 0, 1));
    ack = 1'b1;
    step("pri_ack0",  mk(1, 0, 2, 4'b1010, 1, 1, 1));
    ack = 1'b0;
    step("pri_int1",  mk(1, 1, 1, 4'b1010, 0, 0, 1));
    ack = 1'b1;
    step("pri_ack1",  mk(1, 0, 1, 4'b1000, 1, 1, 1));
    ack = 1'b0;
    step("pri_int3",  mk(1, 1, 3, 4'b1000, 0, 0, 1));
    ack = 1'b1;
    step("pri_ack3",  mk(1, 0, 3, 4'b0000, 1, 1, 1));
    ack = 1'b0; sys_int = '0; sys_exc = 1'b0;
    tick(3);

    msk = 4'b0001; sys_int = 4'b0001;
    tick(1);
    step("msk_pend",  mk(1, 0, 3, 4'b0001, 1, 1, 1));
    step("msk_hold",  mk(1, 0, 3, 4'b0001, 1, 1, 1));
    msk = '0;
    step("msk_enter", mk(1, 1, 0, 4'b0001, 0, 0, 1));
    ack = 1'b1;
    step("msk_ack",   mk(1, 0, 0, 4'b0000, 1, 1, 1));
    ack = 1'b0; sys_int = '0;
    tick(3);

    ie = 1'b0; sys_int = 4'b0001;
    tick(1);
    step("ie_pend",   mk(1, 0, 0, 4'b0001, 1, 1, 1));
    step("ie_hold",   mk(1, 0, 0, 4'b0001, 1, 1, 1));
    ie = 1'b1;
    step("ie_enter",  mk(1, 1, 0, 4'b0001, 0, 0, 1));
    ack = 1'b1;
    step("ie_ack",    mk(1, 0, 0, 4'b0000, 1, 1, 1));
    ack = 1'b0; sys_int = '0;
    tick(3);

    iwbstb = 1'b1;
    #1;
    now("stall_nrun", mk(1, 0, 0, 4'b0000, 1, 1, 0));
    sys_int = 4'b0100;
    push("stall_freeze", mk(1, 0, 0, 4'b0000, 1, 1, 0));
    tick(3);
    drain();
    iwbstb = 1'b0;
    step("stall_s1",    mk(1, 0, 0, 4'b0000, 1, 1, 1));
    step("stall_pend",  mk(1, 0, 0, 4'b0100, 1, 1, 1));
    iwbstb = 1'b1;
    step("stall_norun", mk(1, 0, 0, 4'b0100, 1, 1, 0));
    iwbstb = 1'b0;
    step("stall_enter", mk(1, 1, 2, 4'b0100, 0, 0, 1));
    iwbstb = 1'b1; ack = 1'b1;
    step("stall_ack",   mk(1, 0, 2, 4'b0000, 1, 1, 0));
    ack = 1'b0; iwbstb = 1'b0; sys_int = '0;
    tick(3);

    bra = 1'b1;
    step("bub_bra", mk(1, 0, 2, 4'b0000, 0, 0, 1));
    dly = 1'b1;
    step("bub_dly", mk(1, 0, 2, 4'b0000, 1, 0, 1));
    bra = 1'b0; dly = 1'b0;
    step("bub_clr", mk(1, 0, 2, 4'b0000, 1, 1, 1));

    sys_int = 4'b0010;
    tick(1);
    swx = 1'b1;
    step("swx_pend",  mk(1, 0, 2, 4'b0010, 1, 1, 1));
    swx = 1'b0;
    step("swx_enter", mk(1, 3, 2, 4'b0010, 0, 0, 1));
    ack = 1'b1;
    step("swx_ack",   mk(1, 0, 2, 4'b0010, 1, 1, 1));
    ack = 1'b0;
    step("swx_int",   mk(1, 1, 1, 4'b0010, 0, 0, 1));

    rst_n = 1'b0;
    #1;
    now("rst_mid", mk(0, 0, 0, 4'b0000, 1, 1, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aemb_sysctl.md
# aemb_sysctl

Parametrised system control unit for the aeMB core: successor to the single-interrupt control block. Generates the core clock and stretched reset, the bus-quiet run strobe and fetch/decode bubbles. Debounces and edge-qualifies one hardware exception and `NINT` maskable interrupt lines, plus a software exception request. Arbitrates them through an acknowledge-handshaked state machine whose state and winning interrupt ID feed the core's vector logic.

## Interface
- `NINT`, 4: interrupt channels, 1..32.
- `DEB`, 3: debounce depth in samples, ≥2.
- `RSTLEN`, 2: reset stretch in clock cycles, ≥1.
- `IW`, `$clog2(NINT)` (min 1): interrupt ID width, derived.

Ports:
- `sys_clk_i` in 1: the single clock.
- `sys_rst_i` in 1: reset, asynchronous, active-low.
- `sys_int_i` in NINT: raw interrupt lines.
- `sys_exc_i` in 1: raw hardware exception line.
- `swx_i` in 1: software exception request, 1-cycle pulse from decode.
- `ie_i` in 1: global interrupt enable (MSR.IE).
- `int_msk_i` in NINT: per-channel mask, 1 = blocked.
- `ack_i` in 1: core has taken the vector, 1-cycle pulse.
- `rIWBSTB`, `iwb_ack_i`, `rDWBSTB`, `dwb_ack_i` in 1 each: bus strobes and acks.
- `rBRA`, `rDLY` in 1 each: branch taken and delay slot.
- `nclk` out 1: equals `sys_clk_i`.
- `nrst` out 1: stretched internal reset, active-low.
- `nrun` out 1: bus-quiet strobe.
- `frun`, `drun` out 1 each: fetch and decode enables.
- `rFSM` out 2: arbiter state.
- `int_id_o` out IW: serviced channel.
- `pend_o` out NINT: pending interrupt flags.

## Operation
- `nrst`: shift register of `RSTLEN` bits. Cleared asynchronously by `sys_rst_i`, then shifts in 1 each clock. `nrst` is the MSB. All other state is async-cleared by `sys_rst_i` and held in reset while `nrst`=0.
- `nrun = ~((rDWBSTB^dwb_ack_i) | (rIWBSTB^iwb_ack_i))`, combinational.
- Debounce: each input (exc plus NINT ints) has a `DEB`-bit shift register that advances only when `nrun`=1.
  - Qualified edge: the newest `DEB-1` samples are 1 and the oldest is 0.
  - An exc edge sets `exc_pend`. An int edge on channel i sets `pend[i]`. A `swx_i` pulse sets `swx_pend`.
  - Set beats a same-cycle clear.
- Eligible interrupts: `pend & ~int_msk_i`, considered only when `ie_i`=1. Priority: lowest index wins.
- States (package constants): RUN=0, HWINT=1, HWEXC=2, SWEXC=3.
  - RUN, `nrun`=1: go to SWEXC if `swx_pend`; else HWEXC if `exc_pend`; else HWINT if any eligible interrupt, latching the winner into `int_id_o`; else stay in RUN.
  - HWINT/HWEXC/SWEXC: on `ack_i`=1, return to RUN and clear the serviced flag (`pend[int_id_o]`, `exc_pend` or `swx_pend`). `ack_i` is ignored in RUN.
  - `int_id_o` holds its value outside HWINT.
- Bubbles: registered `{drun,frun}`.
  - Next value is `{~(rBRA^rDLY), ~rBRA}` when the next state is RUN, else `2'b00`.
- `pend_o` = `pend`. A masked channel stays pending until it is serviced.

## Timing
- Reset values: `nrst`=0, `rFSM`=RUN, `int_id_o`=0, `pend_o`=0, `frun`=`drun`=1. `nclk` and `nrun` follow their inputs.
- `nrst` rises on the `RSTLEN`-th rising edge after `sys_rst_i` deasserts. Reset assertion mid-operation clears everything immediately.
- All state updates on the rising `sys_clk_i` edge.
- Input stable high from a 0 history: pending flag sets at the `DEB-1`-th `nrun`-qualified sample. HWINT is entered on the following `nrun` edge.
- State leaves RUN exactly one cycle after the flag is visible. `frun`/`drun` drop the same edge.
- `nrun`=0 freezes debounce and RUN transitions. The `ack_i` return is not gated.
- A level held high does not re-trigger. The line must fall for at least one sample.

## Structure
- `aemb_sysctl_pkg`: state encodings (RUN/HWINT/HWEXC/SWEXC) and the 2-bit state width.
- Sub-module `aemb_sysctl_deb #(DEB)`: one line's shift register plus edge qualifier. Instantiated NINT+1 times by generate.
- Priority encoder: a function in the top module.

## Test plan
- Reset: `sys_rst_i` low, then release with RSTLEN=2 -> `nrst` rises on the 2nd edge; `frun`=`drun`=1, `rFSM`=0, `pend_o`=0.
- Interrupt: NINT=4, DEB=3, `ie_i`=1, `sys_int_i`=4'b0100 held -> `pend_o`=4'b0100 after 2 samples; next edge `rFSM`=1, `int_id_o`=2, `frun`=`drun`=0; `ack_i` pulse -> `rFSM`=0, `pend_o`=0.
- Priority: `sys_int_i`=4'b1010 and an exc edge together -> HWEXC first; after ack, HWINT with `int_id_o`=1; after ack, HWINT with `int_id_o`=3.
- Masking: `int_msk_i`=4'b0001, int0 edge -> `pend_o[0]`=1, `rFSM` stays 0; unmask -> HWINT with id 0. Repeat with `ie_i`=0 -> no entry.
- Bus stall: hold `rIWBSTB`=1, `iwb_ack_i`=0 -> `nrun`=0, debounce and state frozen; release -> resumes, same final result.
- Bubbles and software exception: `rBRA`=1, `rDLY`=0 -> `frun`=0, `drun`=0; `rBRA`=`rDLY`=1 -> `frun`=0, `drun`=1; `swx_i` pulse while an interrupt is pending -> SWEXC taken first.
